// File: rtl/coh_noc_pkg.sv
// Shared NoC types and widths for the crosspoint (XP) port blocks.
//   flit_t             : one flit as carried on the port
//   CREDIT_COUNT_WIDTH : width of credit / occupancy counters
//   XP_VC_ID_WIDTH     : width of VC identifiers on XP ports
package coh_noc_pkg;

  localparam int FLIT_WIDTH         = 32;
  localparam int CREDIT_COUNT_WIDTH = 4;
  localparam int XP_VC_ID_WIDTH     = 4;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

endpackage

// File: rtl/xp_port_rx_vc_fifo.sv
// Per-VC flit FIFO of the XP receive port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write push_data_i at the write pointer
//   push_data_i  flit to write
//   pop_i        retire the head entry
//   flush_i      empty the FIFO at this edge (wins over push/pop)
//   head_o       flit at the read pointer
//   occ_o        number of entries held, 0..DEPTH
module xp_port_rx_vc_fifo
  import coh_noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  flit_t                         push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output flit_t                         head_o,
  output logic [CREDIT_COUNT_WIDTH-1:0] occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]                 wr_q, rd_q;
  logic [CREDIT_COUNT_WIDTH-1:0] occ_q, occ_d;
  flit_t                         mem_q [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_i) wr_q <= ptr_inc(wr_q);
        if (pop_i)  rd_q <= ptr_inc(rd_q);
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/xp_port_rx.sv
// XP router port receive buffer: per-VC flit FIFOs fed by a valid/ready
// upstream link, per-VC credit advertisement and flush, and a round-robin
// arbitrated single output towards the crossbar.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid/ready/flit      upstream flit handshake
//   vc_id                 VC of incoming flit, credit query and flush
//   credit_count          free slots in VC vc_id
//   credit_return         flush VC vc_id
//   out_valid/out_ready   crossbar handshake, out_flit/out_vc its payload
// Optional (macro XP_PORT_RX_STATS_EN):
//   stat_accepted         wrapping count of accepted flits
//   stat_flushed          wrapping count of flits discarded by flush
module xp_port_rx
  import coh_noc_pkg::*;
#(
  parameter int NUM_VC   = 4,
  parameter int VC_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  output logic                          ready,
  input  flit_t                         flit,
  input  logic [XP_VC_ID_WIDTH-1:0]     vc_id,
  output logic [CREDIT_COUNT_WIDTH-1:0] credit_count,
  input  logic                          credit_return,
  output logic                          out_valid,
  input  logic                          out_ready,
  output flit_t                         out_flit,
  output logic [XP_VC_ID_WIDTH-1:0]     out_vc
`ifdef XP_PORT_RX_STATS_EN
  ,
  output logic [31:0]                   stat_accepted,
  output logic [31:0]                   stat_flushed
`endif
);

  if (VC_DEPTH < 1 || VC_DEPTH >= 2**CREDIT_COUNT_WIDTH) begin : g_bad_depth
    $error("xp_port_rx: VC_DEPTH must be in 1..2**CREDIT_COUNT_WIDTH-1");
  end
  if (NUM_VC < 1 || NUM_VC > 16) begin : g_bad_num_vc
    $error("xp_port_rx: NUM_VC must be in 1..16");
  end

  logic [CREDIT_COUNT_WIDTH-1:0] occ  [NUM_VC];
  flit_t                         head [NUM_VC];
  logic [NUM_VC-1:0]             push_v, pop_v, flush_v, nonempty;

  logic                          vc_ok;
  logic [CREDIT_COUNT_WIDTH-1:0] sel_occ;
  logic [XP_VC_ID_WIDTH-1:0]     rr_q, rr_d, lock_vc_q, lock_vc_d, grant;
  logic                          lock_q, lock_d, lock_hit, found;
  flit_t                         grant_flit;
  logic                          grant_flushed;

  assign vc_ok = 32'(vc_id) < NUM_VC;

  always_comb begin
    sel_occ = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (vc_id == XP_VC_ID_WIDTH'(v)) sel_occ = occ[v];
    end
  end

  // ready looks at registered occupancy only, so a full VC that is being
  // popped this cycle still refuses the incoming flit.
  assign ready        = rst_n && vc_ok && !credit_return
                        && (sel_occ < CREDIT_COUNT_WIDTH'(VC_DEPTH));
  assign credit_count = (rst_n && vc_ok) ? CREDIT_COUNT_WIDTH'(VC_DEPTH) - sel_occ : '0;

  // Arbiter: hold a stalled grant, otherwise search from the VC after rr_q.
  always_comb begin
    lock_hit = 1'b0;
    found    = 1'b0;
    grant    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      nonempty[v] = (occ[v] != '0);
      if (lock_q && lock_vc_q == XP_VC_ID_WIDTH'(v) && nonempty[v]) lock_hit = 1'b1;
    end
    if (lock_hit) begin
      found = 1'b1;
      grant = lock_vc_q;
    end else begin
      for (int i = 1; i <= NUM_VC; i++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          if (!found && nonempty[v]
              && ((int'(rr_q) + i == v) || (int'(rr_q) + i - NUM_VC == v))) begin
            found = 1'b1;
            grant = XP_VC_ID_WIDTH'(v);
          end
        end
      end
    end
  end

  always_comb begin
    grant_flit    = '0;
    grant_flushed = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_v[v]  = valid && ready && (vc_id == XP_VC_ID_WIDTH'(v));
      pop_v[v]   = out_valid && out_ready && (grant == XP_VC_ID_WIDTH'(v));
      flush_v[v] = credit_return && (vc_id == XP_VC_ID_WIDTH'(v));
      if (grant == XP_VC_ID_WIDTH'(v)) begin
        grant_flit    = head[v];
        grant_flushed = flush_v[v];
      end
    end
  end

  assign out_valid = rst_n && found;
  assign out_flit  = out_valid ? grant_flit : '0;
  assign out_vc    = out_valid ? grant : '0;

  always_comb begin
    rr_d      = (out_valid && out_ready) ? grant : rr_q;
    lock_d    = out_valid && !out_ready && !grant_flushed;
    lock_vc_d = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= XP_VC_ID_WIDTH'(NUM_VC - 1);
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    xp_port_rx_vc_fifo #(.DEPTH(VC_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_v[g]),
      .push_data_i (flit),
      .pop_i       (pop_v[g]),
      .flush_i     (flush_v[g]),
      .head_o      (head[g]),
      .occ_o       (occ[g])
    );
  end

`ifdef XP_PORT_RX_STATS_EN
  logic [31:0] acc_q, acc_d, fl_q, fl_d;

  // A flit popped in the same cycle as the flush was delivered, not dropped.
  always_comb begin
    acc_d = acc_q + {31'd0, |push_v};
    fl_d  = fl_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (flush_v[v]) fl_d = fl_q + 32'(occ[v]) - {31'd0, pop_v[v]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      fl_q  <= '0;
    end else begin
      acc_q <= acc_d;
      fl_q  <= fl_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_flushed  = fl_q;
`endif

endmodule

// File: tb/tb_xp_port_rx.sv
module tb_xp_port_rx;
  import coh_noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  flit_t       flit = '0;
  logic [3:0]  vc_id = '0;
  logic [3:0]  credit_count;
  logic        credit_return = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  flit_t       out_flit;
  logic [3:0]  out_vc;
`ifdef XP_PORT_RX_STATS_EN
  logic [31:0] stat_accepted, stat_flushed;
`endif

  always #5 clk = ~clk;

  xp_port_rx #(.NUM_VC(4), .VC_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid         (valid),
    .ready         (ready),
    .flit          (flit),
    .vc_id         (vc_id),
    .credit_count  (credit_count),
    .credit_return (credit_return),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_vc        (out_vc)
`ifdef XP_PORT_RX_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_flushed  (stat_flushed)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [3:0] vc, input logic cr,
                       input logic ordy, input logic [31:0] f);
    @(negedge clk);
    valid = v; vc_id = vc; credit_return = cr; out_ready = ordy; flit = f;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic e_rdy, input logic [3:0] e_cc,
                          input logic e_ov, input logic [3:0] e_ovc, input logic [31:0] e_of);
    chk({tag, ".ready"},        ready,        e_rdy);
    chk({tag, ".credit_count"}, credit_count, e_cc);
    chk({tag, ".out_valid"},    out_valid,    e_ov);
    chk({tag, ".out_vc"},       out_vc,       e_ovc);
    chk({tag, ".out_flit"},     out_flit,     e_of);
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  vc;
    logic        cr;
    logic        ordy;
    logic [31:0] flit;
    logic        e_rdy;
    logic [3:0]  e_cc;
    logic        e_ov;
    logic [3:0]  e_ovc;
    logic [31:0] e_of;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] vc, logic cr, logic ordy, logic [31:0] f,
                              logic e_rdy, logic [3:0] e_cc, logic e_ov, logic [3:0] e_ovc,
                              logic [31:0] e_of);
    vec_t r;
    r.valid = v; r.vc = vc; r.cr = cr; r.ordy = ordy; r.flit = f;
    r.e_rdy = e_rdy; r.e_cc = e_cc; r.e_ov = e_ov; r.e_ovc = e_ovc; r.e_of = e_of;
    return r;
  endfunction

  localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
  localparam logic [31:0] A4 = 32'hA000_0004, A5 = 32'hA000_0005, A6 = 32'hA000_0006;

  vec_t tbl [17];
  logic [31:0] arb_flit [6];
  logic [3:0]  arb_vc   [6];

  initial begin
    // Fill VC2, overflow attempt, steady push+pop while full, out-of-range
    // VC query/flush, then drain.
    tbl[0]  = mk(0, 2, 0, 0, 0,  1, 4, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0, A1, 1, 4, 0, 0, 0);
    tbl[2]  = mk(1, 2, 0, 0, A2, 1, 3, 1, 2, A1);
    tbl[3]  = mk(1, 2, 0, 0, A3, 1, 2, 1, 2, A1);
    tbl[4]  = mk(1, 2, 0, 0, A4, 1, 1, 1, 2, A1);
    tbl[5]  = mk(1, 2, 0, 0, A5, 0, 0, 1, 2, A1);
    tbl[6]  = mk(1, 2, 0, 1, A5, 0, 0, 1, 2, A1);
    tbl[7]  = mk(1, 2, 0, 1, A5, 1, 1, 1, 2, A2);
    tbl[8]  = mk(1, 2, 0, 1, A6, 1, 1, 1, 2, A3);
    tbl[9]  = mk(0, 2, 0, 0, 0,  1, 1, 1, 2, A4);
    tbl[10] = mk(1, 15, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 2, A4);
    tbl[11] = mk(0, 2, 0, 0, 0,  1, 1, 1, 2, A4);
    tbl[12] = mk(0, 0, 0, 0, 0,  1, 4, 1, 2, A4);
    tbl[13] = mk(0, 2, 0, 1, 0,  1, 1, 1, 2, A4);
    tbl[14] = mk(0, 2, 0, 1, 0,  1, 2, 1, 2, A5);
    tbl[15] = mk(0, 2, 0, 1, 0,  1, 3, 1, 2, A6);
    tbl[16] = mk(0, 2, 0, 0, 0,  1, 4, 0, 0, 0);

    arb_flit[0] = 32'hC000_0000; arb_vc[0] = 0;
    arb_flit[1] = 32'hD000_0000; arb_vc[1] = 1;
    arb_flit[2] = 32'hE000_0000; arb_vc[2] = 3;
    arb_flit[3] = 32'hC000_0001; arb_vc[3] = 0;
    arb_flit[4] = 32'hD000_0001; arb_vc[4] = 1;
    arb_flit[5] = 32'hE000_0001; arb_vc[5] = 3;

    // Reset state, with inputs that would otherwise produce ready=1.
    drive(1, 0, 0, 1, 32'h1234_5678);
    chk_outs("reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].vc, tbl[i].cr, tbl[i].ordy, tbl[i].flit);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_cc, tbl[i].e_ov,
               tbl[i].e_ovc, tbl[i].e_of);
    end

    // Round-robin: load VC0,VC0,VC1,VC1,VC3,VC3 with out_ready=0. VC0 is
    // granted first and must stay granted even after VC3 (which follows
    // the last-served VC2) becomes non-empty.
    drive(1, 0, 0, 0, arb_flit[0]);
    chk("arb_load0.out_valid", out_valid, 0);
    drive(1, 0, 0, 0, arb_flit[3]);
    chk_outs("arb_load1", 1, 3, 1, 0, arb_flit[0]);
    drive(1, 1, 0, 0, arb_flit[1]);
    chk_outs("arb_load2", 1, 4, 1, 0, arb_flit[0]);
    drive(1, 1, 0, 0, arb_flit[4]);
    chk_outs("arb_load3", 1, 3, 1, 0, arb_flit[0]);
    drive(1, 3, 0, 0, arb_flit[2]);
    chk_outs("arb_load4", 1, 4, 1, 0, arb_flit[0]);
    drive(1, 3, 0, 0, arb_flit[5]);
    chk_outs("arb_load5", 1, 3, 1, 0, arb_flit[0]);
    for (int j = 0; j < 6; j++) begin
      drive(0, 0, 0, 1, 0);
      chk($sformatf("arb_pop%0d.out_vc", j),   out_vc,   arb_vc[j]);
      chk($sformatf("arb_pop%0d.out_flit", j), out_flit, arb_flit[j]);
    end
    drive(0, 0, 0, 0, 0);
    chk("arb_drained.out_valid", out_valid, 0);

    // Flush VC1 holding 3 flits, with a same-cycle valid that must be refused.
    drive(1, 1, 0, 0, 32'hB000_0000);
    drive(1, 1, 0, 0, 32'hB000_0001);
    drive(1, 1, 0, 0, 32'hB000_0002);
    drive(1, 1, 1, 0, 32'hB000_0003);
    chk_outs("flush_req", 0, 1, 1, 1, 32'hB000_0000);
    drive(0, 1, 0, 0, 0);
    chk_outs("flush_after", 1, 4, 0, 0, 0);
`ifdef XP_PORT_RX_STATS_EN
    chk("flush.stat_flushed",  stat_flushed,  3);
    chk("flush.stat_accepted", stat_accepted, 15);
`endif

    // Flush VC0 in the same cycle its head is popped.
    drive(1, 0, 0, 0, 32'hF000_0000);
    drive(1, 0, 0, 0, 32'hF000_0001);
    drive(0, 0, 1, 1, 0);
    chk_outs("flushpop_req", 0, 2, 1, 0, 32'hF000_0000);
    drive(0, 0, 0, 0, 0);
    chk_outs("flushpop_after", 1, 4, 0, 0, 0);
`ifdef XP_PORT_RX_STATS_EN
    chk("flushpop.stat_flushed",  stat_flushed,  4);
    chk("flushpop.stat_accepted", stat_accepted, 17);
`endif

    // Asynchronous reset with 2 flits buffered in VC0.
    drive(1, 0, 0, 0, 32'h9000_0000);
    drive(1, 0, 0, 0, 32'h9000_0001);
    drive(1, 0, 0, 0, 0);
    valid = 1'b0;
    chk_outs("pre_rst", 1, 2, 1, 0, 32'h9000_0000);
    #1 rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", 0, 0, 0, 0, 0);
`ifdef XP_PORT_RX_STATS_EN
    chk("mid_rst.stat_accepted", stat_accepted, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs("post_rst", 1, 4, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
